// File: rtl/sequenciador_instrucoes_if.sv
// Control bundle between the instruction sequencer and the datapath/IR it drives.
// master: the side that supplies Run/IR/G and observes the enables; slave: the sequencer.
interface sequenciador_instrucoes_if;
  logic        Run;
  logic [9:0]  Instrucao;
  logic [15:0] GRout;
  logic        IRin;
  logic [7:0]  Rin;
  logic [7:0]  Rout;
  logic        Ain;
  logic        Gin;
  logic        Gout;
  logic        DINout;
  logic [1:0]  Ulaop;
  logic        ADDRin;
  logic        AddrSel;
  logic        DOUTin;
  logic        W_D;
  logic        IncrPc;
  logic        Done;
  logic        Busy;
  logic [2:0]  Tstep;

  modport master (
    output Run, Instrucao, GRout,
    input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, Ulaop, ADDRin, AddrSel, DOUTin, W_D,
    input  IncrPc, Done, Busy, Tstep
  );

  modport slave (
    input  Run, Instrucao, GRout,
    output IRin, Rin, Rout, Ain, Gin, Gout, DINout, Ulaop, ADDRin, AddrSel, DOUTin, W_D,
    output IncrPc, Done, Busy, Tstep
  );
endinterface

// File: rtl/sequenciador_instrucoes.sv
// Multicycle processor control unit: steps fetch/execute and decodes every datapath enable
// from the current step and the IR contents.
module sequenciador_instrucoes #(
  parameter int unsigned MEM_LAT = 1
) (
  input logic                     Clock,
  input logic                     Reset,
  sequenciador_instrucoes_if.slave bus
);

  typedef enum logic {StIdle, StRun} state_t;

  localparam logic [2:0] LatW     = 3'(MEM_LAT);
  localparam logic [2:0] ExecStep = 3'(MEM_LAT + 2);

  state_t     state_q;
  logic [2:0] step_q;
  logic [2:0] k;
  logic [3:0] opcode;
  logic [7:0] rx_oh;
  logic [7:0] ry_oh;
  logic       done_c;

  assign opcode = bus.Instrucao[9:6];
  assign rx_oh  = 8'h80 >> bus.Instrucao[5:3];
  assign ry_oh  = 8'h80 >> bus.Instrucao[2:0];

  // Enables are decoded from the step register rather than registered themselves, because the
  // first execute step must see the IR value loaded by the preceding IRin.
  always_comb begin
    bus.IRin    = 1'b0;
    bus.Rin     = 8'h00;
    bus.Rout    = 8'h00;
    bus.Ain     = 1'b0;
    bus.Gin     = 1'b0;
    bus.Gout    = 1'b0;
    bus.DINout  = 1'b0;
    bus.Ulaop   = 2'b00;
    bus.ADDRin  = 1'b0;
    bus.AddrSel = 1'b0;
    bus.DOUTin  = 1'b0;
    bus.W_D     = 1'b0;
    bus.IncrPc  = 1'b0;
    done_c      = 1'b0;
    k           = step_q - ExecStep;
    if (state_q == StRun) begin
      if (step_q < ExecStep) begin
        bus.ADDRin = (step_q == 3'd0);
        bus.IncrPc = (step_q == 3'd1);
        bus.IRin   = (step_q == LatW + 3'd1);
      end else begin
        case (opcode)
          4'b0000: begin
            bus.Rout = ry_oh;
            bus.Rin  = rx_oh;
            done_c   = 1'b1;
          end
          4'b0001: begin
            if (k == 3'd0) begin
              bus.ADDRin = 1'b1;
            end else if (k <= LatW) begin
              bus.IncrPc = (k == 3'd1);
            end else begin
              bus.DINout = 1'b1;
              bus.Rin    = rx_oh;
              done_c     = 1'b1;
            end
          end
          4'b0010, 4'b0011: begin
            if (k == 3'd0) begin
              bus.Rout = rx_oh;
              bus.Ain  = 1'b1;
            end else if (k == 3'd1) begin
              bus.Rout  = ry_oh;
              bus.Gin   = 1'b1;
              bus.Ulaop = {1'b0, opcode[0]};
            end else begin
              bus.Gout = 1'b1;
              bus.Rin  = rx_oh;
              done_c   = 1'b1;
            end
          end
          4'b0100: begin
            if (k == 3'd0) begin
              bus.Rout    = ry_oh;
              bus.ADDRin  = 1'b1;
              bus.AddrSel = 1'b1;
            end else if (k > LatW) begin
              bus.DINout = 1'b1;
              bus.Rin    = rx_oh;
              done_c     = 1'b1;
            end
          end
          4'b0101: begin
            if (k == 3'd0) begin
              bus.Rout    = ry_oh;
              bus.ADDRin  = 1'b1;
              bus.AddrSel = 1'b1;
            end else if (k == 3'd1) begin
              bus.Rout   = rx_oh;
              bus.DOUTin = 1'b1;
            end else begin
              bus.W_D = 1'b1;
              done_c  = 1'b1;
            end
          end
          4'b0110: begin
            if (bus.GRout != 16'h0000) begin
              bus.Rout = ry_oh;
              bus.Rin  = rx_oh;
            end
            done_c = 1'b1;
          end
          default: done_c = 1'b1;
        endcase
      end
    end
    bus.Done  = done_c;
    bus.Busy  = (state_q == StRun);
    bus.Tstep = step_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      step_q  <= 3'd0;
    end else begin
      case (state_q)
        StIdle: begin
          step_q <= 3'd0;
          if (bus.Run) state_q <= StRun;
        end
        StRun: begin
          if (done_c) begin
            step_q  <= 3'd0;
            state_q <= bus.Run ? StRun : StIdle;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          step_q  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_instrucoes.sv
// Scoreboard bench: two sequencers (MEM_LAT 1 and 2) run directed and random programs while a
// monitor compares every cycle against a micro-step list model.
module tb_sequenciador_instrucoes;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic [1:0] ulaop;
    logic       addrin;
    logic       addrsel;
    logic       doutin;
    logic       wd;
    logic       incrpc;
    logic       done;
    logic       busy;
    logic [2:0] tstep;
  } outv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst0, rst1;
  int    checks = 0;
  int    passed = 0;
  bit    timed_out = 1'b0;
  outv_t expq[2][$];
  outv_t trq[2][$];
  outv_t act0, act1;

  sequenciador_instrucoes_if bus0();
  sequenciador_instrucoes_if bus1();

  sequenciador_instrucoes #(.MEM_LAT(1)) dut0 (.Clock(clk), .Reset(rst0), .bus(bus0));
  sequenciador_instrucoes #(.MEM_LAT(2)) dut1 (.Clock(clk), .Reset(rst1), .bus(bus1));

  assign act0 = {bus0.IRin, bus0.Rin, bus0.Rout, bus0.Ain, bus0.Gin, bus0.Gout, bus0.DINout,
                 bus0.Ulaop, bus0.ADDRin, bus0.AddrSel, bus0.DOUTin, bus0.W_D, bus0.IncrPc,
                 bus0.Done, bus0.Busy, bus0.Tstep};
  assign act1 = {bus1.IRin, bus1.Rin, bus1.Rout, bus1.Ain, bus1.Gin, bus1.Gout, bus1.DINout,
                 bus1.Ulaop, bus1.ADDRin, bus1.AddrSel, bus1.DOUTin, bus1.W_D, bus1.IncrPc,
                 bus1.Done, bus1.Busy, bus1.Tstep};

  function automatic logic [7:0] oh(input logic [2:0] r);
    return 8'h80 >> r;
  endfunction

  task automatic push_step(input int ln, input outv_t v);
    v.busy  = 1'b1;
    v.tstep = 3'(trq[ln].size());
    trq[ln].push_back(v);
  endtask

  // Expected enable list for one whole instruction, one entry per step.
  task automatic build(input int ln, input logic [9:0] ins, input logic [15:0] gr);
    int         lat;
    outv_t      v;
    logic [3:0] op;
    logic [2:0] rx, ry;
    lat = ln + 1;
    op  = ins[9:6];
    rx  = ins[5:3];
    ry  = ins[2:0];
    trq[ln].delete();
    v = '0; v.addrin = 1'b1; push_step(ln, v);
    for (int i = 1; i <= lat; i++) begin v = '0; v.incrpc = (i == 1); push_step(ln, v); end
    v = '0; v.irin = 1'b1; push_step(ln, v);
    case (op)
      4'd0: begin v = '0; v.rout = oh(ry); v.rin = oh(rx); push_step(ln, v); end
      4'd1: begin
        v = '0; v.addrin = 1'b1; push_step(ln, v);
        for (int i = 1; i <= lat; i++) begin v = '0; v.incrpc = (i == 1); push_step(ln, v); end
        v = '0; v.dinout = 1'b1; v.rin = oh(rx); push_step(ln, v);
      end
      4'd2, 4'd3: begin
        v = '0; v.rout = oh(rx); v.ain = 1'b1; push_step(ln, v);
        v = '0; v.rout = oh(ry); v.gin = 1'b1; v.ulaop = (op == 4'd3) ? 2'b01 : 2'b00;
        push_step(ln, v);
        v = '0; v.gout = 1'b1; v.rin = oh(rx); push_step(ln, v);
      end
      4'd4: begin
        v = '0; v.rout = oh(ry); v.addrin = 1'b1; v.addrsel = 1'b1; push_step(ln, v);
        for (int i = 1; i <= lat; i++) begin v = '0; push_step(ln, v); end
        v = '0; v.dinout = 1'b1; v.rin = oh(rx); push_step(ln, v);
      end
      4'd5: begin
        v = '0; v.rout = oh(ry); v.addrin = 1'b1; v.addrsel = 1'b1; push_step(ln, v);
        v = '0; v.rout = oh(rx); v.doutin = 1'b1; push_step(ln, v);
        v = '0; v.wd = 1'b1; push_step(ln, v);
      end
      4'd6: begin
        v = '0;
        if (gr != 16'h0000) begin v.rout = oh(ry); v.rin = oh(rx); end
        push_step(ln, v);
      end
      default: begin v = '0; push_step(ln, v); end
    endcase
    v = trq[ln].pop_back();
    v.done = 1'b1;
    trq[ln].push_back(v);
  endtask

  // One clock of stimulus; the expected outputs for that same cycle go to the scoreboard.
  task automatic cyc(input int ln, input logic r, input logic rn, input logic [9:0] ins,
                     input logic [15:0] gr, input outv_t e);
    @(posedge clk);
    #1;
    if (ln == 0) begin
      rst0 = r; bus0.Run = rn; bus0.Instrucao = ins; bus0.GRout = gr;
    end else begin
      rst1 = r; bus1.Run = rn; bus1.Instrucao = ins; bus1.GRout = gr;
    end
    expq[ln].push_back(e);
  endtask

  task automatic idle(input int ln, input int n, input bit go);
    for (int i = 0; i < n; i++)
      cyc(ln, 1'b0, (i == n - 1) ? go : 1'b0, 10'($urandom), 16'($urandom), '0);
  endtask

  // IR and G are scrambled wherever the sequencer must not depend on them.
  task automatic run_instr(input int ln, input logic [9:0] ins, input logic [15:0] gr,
                           input bit next_run, input int abort_at);
    int exec_at;
    exec_at = ln + 3;
    build(ln, ins, gr);
    for (int i = 0; i < trq[ln].size(); i++) begin
      logic [9:0]  iv;
      logic [15:0] gv;
      logic        rv;
      iv = (i < exec_at) ? 10'($urandom) : ins;
      gv = (i == exec_at) ? gr : 16'($urandom);
      rv = (i == trq[ln].size() - 1) ? next_run : 1'($urandom);
      cyc(ln, (i == abort_at), rv, iv, gv, trq[ln][i]);
      if (i == abort_at) break;
    end
  endtask

  task automatic stim(input int ln);
    logic [3:0] op;
    bit         nr;
    cyc(ln, 1'b1, 1'b1, 10'h0, 16'h0, '0);
    cyc(ln, 1'b0, 1'b1, 10'h0, 16'h0, '0);
    run_instr(ln, 10'b0000_010_101, 16'h1234, 1'b1, -1);
    run_instr(ln, 10'b0010_001_011, 16'h0000, 1'b1, -1);
    run_instr(ln, 10'b0001_111_000, 16'h0000, 1'b1, -1);
    run_instr(ln, 10'b0101_000_100, 16'h0000, 1'b1, -1);
    run_instr(ln, 10'b0011_110_010, 16'h0000, 1'b1, -1);
    run_instr(ln, 10'b0100_111_001, 16'h0000, 1'b1, -1);
    run_instr(ln, 10'b0110_011_110, 16'h0000, 1'b1, -1);
    run_instr(ln, 10'b0110_011_110, 16'h0100, 1'b1, -1);
    run_instr(ln, 10'b1111_000_000, 16'hffff, 1'b0, -1);
    idle(ln, 2, 1'b1);
    run_instr(ln, 10'b0010_001_011, 16'h0000, 1'b1, ln + 4);
    idle(ln, 3, 1'b1);
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 9) > 7) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      nr = (n == 79) ? 1'b0 : ($urandom_range(0, 3) != 0);
      run_instr(ln, {op, 6'($urandom)}, ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom),
                nr, -1);
      if (!nr) idle(ln, (n == 79) ? 2 : $urandom_range(1, 3), (n != 79));
    end
  endtask

  always @(negedge clk) begin
    for (int ln = 0; ln < 2; ln++) begin
      if (expq[ln].size() > 0) begin
        outv_t e, a;
        e = expq[ln].pop_front();
        a = (ln == 0) ? act0 : act1;
        checks++;
        if (a === e) passed++;
        else $display("FAIL outputs lat=%0d t=%0t: got %h, expected %h", ln + 1, $time, a, e);
        checks++;
        if ((32'(a.rout != 8'h00) + 32'(a.gout) + 32'(a.dinout)) <= 1 &&
            $countones(a.rout) <= 1 && $countones(a.rin) <= 1 && !(a.incrpc && a.rin[0]))
          passed++;
        else $display("FAIL exclusivity lat=%0d t=%0t: got %h, required at most one driver",
                      ln + 1, $time, a);
      end
    end
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.Run = 1'b1; bus0.Instrucao = '0; bus0.GRout = '0;
    bus1.Run = 1'b1; bus1.Instrucao = '0; bus1.GRout = '0;
    fork
      begin
        fork
          stim(0);
          stim(1);
        join
      end
      begin
        repeat (20000) @(posedge clk);
        timed_out = 1'b1;
      end
    join_any
    disable fork;
    @(negedge clk);
    #1;
    if (timed_out) $display("FAIL timeout: got no completion, required completion in 20000 cycles");
    $display("%0d/%0d checks passed", passed, checks + int'(timed_out));
    $finish;
  end

endmodule
